// File: rtl/exe_seq_if.sv
// Handshake bundle between the 3exe tile sequencer and its neighbours (src rx, acc, out ctrl).
// Latency: none, wires only. Backpressure: src_valid gates tile start, out_fin returns drain credit.
interface exe_seq_if #(
    parameter int KW = 6,
    parameter int TW = 8
);
    logic          start;
    logic [TW-1:0] tile_num;
    logic [KW-1:0] k_len;
    logic          src_valid;
    logic          out_fin;

    logic          s_init;
    logic          k_init;
    logic          k_period;
    logic [KW-1:0] k_addr;
    logic          k_fin;
    logic          src_release;
    logic [TW-1:0] tile_idx;
    logic          busy;
    logic          done;

    modport master (
        output start, tile_num, k_len, src_valid, out_fin,
        input  s_init, k_init, k_period, k_addr, k_fin, src_release, tile_idx, busy, done
    );

    modport slave (
        input  start, tile_num, k_len, src_valid, out_fin,
        output s_init, k_init, k_period, k_addr, k_fin, src_release, tile_idx, busy, done
    );
endinterface

// File: rtl/exe_seq.sv
// Tile sequencer: issues s_init/k_init/k_fin and the k-loop address for each tile of a run.
// Latency: s_init 2 cycles after start; k_fin k_len+5 cycles after start; all outputs registered-state decodes.
// Backpressure: tile start waits for src_valid and for fewer than two undrained tiles at the output.
module exe_seq #(
    parameter int KW = 6,
    parameter int TW = 8
) (
    input  logic       clk,
    input  logic       rst,
    exe_seq_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        SRC_WAIT,
        S_INIT,
        K_INIT,
        K_RUN,
        K_FIN,
        DRAIN,
        DONE
    } state_t;

    state_t        state_q,    state_d;
    logic [1:0]    out_pend_q, out_pend_d;
    logic [TW-1:0] tile_idx_q, tile_idx_d;
    logic [TW-1:0] tile_num_q, tile_num_d;
    logic [KW-1:0] k_addr_q,   k_addr_d;
    logic [KW-1:0] k_len_q,    k_len_d;
    logic          k_fin_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            out_pend_q <= '0;
            tile_idx_q <= '0;
            tile_num_q <= '0;
            k_addr_q   <= '0;
            k_len_q    <= '0;
        end else begin
            state_q    <= state_d;
            out_pend_q <= out_pend_d;
            tile_idx_q <= tile_idx_d;
            tile_num_q <= tile_num_d;
            k_addr_q   <= k_addr_d;
            k_len_q    <= k_len_d;
        end
    end

    assign k_fin_now = (state_q == K_FIN);

    always_comb begin
        state_d    = state_q;
        out_pend_d = out_pend_q;
        tile_idx_d = tile_idx_q;
        tile_num_d = tile_num_q;
        k_addr_d   = k_addr_q;
        k_len_d    = k_len_q;

        // Drain credit: a finishing tile and a drained tile in the same cycle cancel out.
        case ({k_fin_now, bus.out_fin})
            2'b10:   out_pend_d = out_pend_q + 2'd1;
            2'b01:   if (out_pend_q != 2'd0) out_pend_d = out_pend_q - 2'd1;
            default: out_pend_d = out_pend_q;
        endcase

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    tile_num_d = bus.tile_num;
                    k_len_d    = bus.k_len;
                    tile_idx_d = '0;
                    state_d    = (bus.tile_num == '0) ? DONE : SRC_WAIT;
                end
            end
            SRC_WAIT: begin
                if (bus.src_valid && (out_pend_q != 2'd2)) state_d = S_INIT;
            end
            S_INIT: state_d = K_INIT;
            K_INIT: begin
                k_addr_d = '0;
                state_d  = K_RUN;
            end
            K_RUN: begin
                if (k_addr_q == k_len_q) begin
                    k_addr_d = '0;
                    state_d  = K_FIN;
                end else begin
                    k_addr_d = k_addr_q + KW'(1);
                end
            end
            K_FIN: begin
                if (tile_idx_q == (tile_num_q - TW'(1))) begin
                    state_d = DRAIN;
                end else begin
                    tile_idx_d = tile_idx_q + TW'(1);
                    state_d    = SRC_WAIT;
                end
            end
            // Look at the post-update count so a drain completing this cycle ends the run now.
            DRAIN: begin
                if (out_pend_d == 2'd0) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.s_init      = (state_q == S_INIT);
    assign bus.k_init      = (state_q == K_INIT);
    assign bus.k_period    = (state_q == K_RUN);
    assign bus.k_addr      = k_addr_q;
    assign bus.k_fin       = k_fin_now;
    assign bus.src_release = k_fin_now;
    assign bus.tile_idx    = tile_idx_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);

endmodule

// File: tb/tb_exe_seq.sv
// Bench for exe_seq: directed scenarios plus randomized runs against a phase-counting reference model.
// Latency: n/a. Backpressure: src_valid and out_fin are randomized to exercise the credit gate.
module tb_exe_seq;
    localparam int KW = 6;
    localparam int TW = 8;

    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_TILE  = 2;
    localparam int M_DRAIN = 3;
    localparam int M_DONE  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exe_seq_if #(.KW(KW), .TW(TW)) bus ();
    exe_seq #(.KW(KW), .TW(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: run mode, phase within the current tile (0 = s_init, 1 = k_init,
    // 2..k_len+2 = k loop, k_len+3 = k_fin), tile index and outstanding-drain count.
    int m_mode = M_IDLE;
    int m_ph   = 0;
    int m_idx  = 0;
    int m_pend = 0;
    int m_n    = 0;
    int m_kl   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle(input logic st, input logic sv, input logic of, input logic r);
        int e_kp, e_kf, e_si, e_ki, e_busy, e_done, e_addr, np;
        @(negedge clk);
        e_si   = (m_mode == M_TILE && m_ph == 0) ? 1 : 0;
        e_ki   = (m_mode == M_TILE && m_ph == 1) ? 1 : 0;
        e_kp   = (m_mode == M_TILE && m_ph >= 2 && m_ph <= m_kl + 2) ? 1 : 0;
        e_kf   = (m_mode == M_TILE && m_ph == m_kl + 3) ? 1 : 0;
        e_busy = (m_mode != M_IDLE) ? 1 : 0;
        e_done = (m_mode == M_DONE) ? 1 : 0;
        e_addr = (e_kp != 0) ? m_ph - 2 : 0;
        check_val("strobes", {bus.s_init, bus.k_init, bus.k_period, bus.k_fin, bus.src_release, bus.busy, bus.done},
                  (e_si << 6) | (e_ki << 5) | (e_kp << 4) | (e_kf << 3) | (e_kf << 2) | (e_busy << 1) | e_done);
        check_val("k_addr", bus.k_addr, e_addr);
        check_val("tile_idx", bus.tile_idx, m_idx);

        rst           = r;
        bus.start     = st;
        bus.src_valid = sv;
        bus.out_fin   = of;

        if (r) begin
            m_mode = M_IDLE; m_ph = 0; m_idx = 0; m_pend = 0;
        end else begin
            np = m_pend + e_kf - ((of && (m_pend + e_kf) > 0) ? 1 : 0);
            case (m_mode)
                M_IDLE: if (st) begin
                    m_n = int'(bus.tile_num); m_kl = int'(bus.k_len); m_idx = 0;
                    m_mode = (m_n == 0) ? M_DONE : M_WAIT;
                end
                M_WAIT: if (sv && m_pend < 2) begin m_mode = M_TILE; m_ph = 0; end
                M_TILE: begin
                    if (e_kf != 0) begin
                        if (m_idx == m_n - 1) m_mode = M_DRAIN;
                        else begin m_idx++; m_mode = M_WAIT; end
                    end else m_ph++;
                end
                M_DRAIN: if (np == 0) m_mode = M_DONE;
                default: m_mode = M_IDLE;
            endcase
            m_pend = np;
        end
    endtask

    task automatic reset_gap();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int t_s, t_kf, t_d, t_ki, cnt_s, cnt_kp, cnt_kf, idx_at;
        bus.start = 0; bus.src_valid = 0; bus.out_fin = 0;
        bus.tile_num = '0; bus.k_len = '0;

        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("reset_busy", bus.busy, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // One tile, k_len 7, drain completes at cycle 20.
        bus.tile_num = 8'd1; bus.k_len = 6'd7;
        t_s = -1; t_kf = -1; t_d = -1;
        for (int rel = 0; rel < 26; rel++) begin
            cycle(rel == 0, 1'b1, rel == 20, 1'b0);
            if (bus.s_init) t_s = rel;
            if (bus.k_fin)  t_kf = rel;
            if (bus.done)   t_d = rel;
        end
        check_val("t1_s_init_at", t_s, 2);
        check_val("t1_k_fin_at", t_kf, 12);
        check_val("t1_done_at", t_d, 21);
        check_val("t1_idle_busy", bus.busy, 0);
        reset_gap();

        // Three tiles with no drain: credit stalls the third tile.
        bus.tile_num = 8'd3; bus.k_len = 6'd3;
        cnt_s = 0; t_s = -1; idx_at = -1;
        for (int rel = 0; rel < 40; rel++) begin
            cycle(rel == 0, 1'b1, 1'b0, 1'b0);
            if (bus.s_init) cnt_s++;
        end
        check_val("t2_stalled_starts", cnt_s, 2);
        check_val("t2_stalled_idx", bus.tile_idx, 2);
        for (int rel = 40; rel < 90; rel++) begin
            cycle(1'b0, 1'b1, (rel == 40) || (rel > 55 && rel % 4 == 0), 1'b0);
            if (bus.s_init && t_s < 0) begin t_s = rel; idx_at = int'(bus.tile_idx); end
        end
        check_val("t2_resume_at", t_s, 42);
        check_val("t2_resume_idx", idx_at, 2);
        check_val("t2_end_busy", bus.busy, 0);
        reset_gap();

        // Empty run.
        bus.tile_num = 8'd0; bus.k_len = 6'd5;
        cnt_s = 0; t_d = -1;
        for (int rel = 0; rel < 6; rel++) begin
            cycle(rel == 0, 1'b1, 1'b0, 1'b0);
            if (bus.s_init || bus.k_init || bus.k_fin) cnt_s++;
            if (bus.done) t_d = rel;
        end
        check_val("t3_done_at", t_d, 1);
        check_val("t3_no_strobes", cnt_s, 0);
        reset_gap();

        // k_len 0, two tiles.
        bus.tile_num = 8'd2; bus.k_len = 6'd0;
        cnt_kp = 0; t_ki = -1; t_kf = -1;
        for (int rel = 0; rel < 30; rel++) begin
            cycle(rel == 0, 1'b1, rel % 5 == 0, 1'b0);
            if (bus.k_period) cnt_kp++;
            if (bus.k_init && t_ki < 0) t_ki = rel;
            if (bus.k_fin && t_kf < 0) t_kf = rel;
        end
        check_val("t4_kperiod_cycles", cnt_kp, 2);
        check_val("t4_kinit_to_kfin", t_kf - t_ki, 2);
        reset_gap();

        // Source not ready for a while.
        bus.tile_num = 8'd1; bus.k_len = 6'd2;
        t_s = -1;
        for (int rel = 0; rel < 30; rel++) begin
            cycle(rel == 0, rel >= 12, rel == 25, 1'b0);
            if (bus.s_init) t_s = rel;
        end
        check_val("t5_s_init_at", t_s, 13);
        reset_gap();

        // Reset mid-loop at k_addr 4, with a stray start while busy beforehand.
        bus.tile_num = 8'd2; bus.k_len = 6'd7;
        for (int rel = 0; rel < 9; rel++) begin
            cycle(rel == 0 || rel == 5, 1'b1, 1'b0, 1'b0);
        end
        check_val("t6_addr_before_rst", bus.k_addr, 4);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check_val("t6_outs_after_rst", {bus.s_init, bus.k_init, bus.k_period, bus.k_addr, bus.k_fin,
                                        bus.src_release, bus.tile_idx, bus.busy, bus.done}, 0);
        for (int rel = 0; rel < 4; rel++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
        reset_gap();

        // Randomized runs.
        for (int run = 0; run < 30; run++) begin
            bus.tile_num = TW'($urandom_range(0, 4));
            bus.k_len    = KW'($urandom_range(0, 5));
            for (int rel = 0; rel < 300; rel++) begin
                if (rel > 2 && m_mode == M_IDLE) break;
                cycle(rel == 0 || ($urandom_range(0, 19) == 0),
                      $urandom_range(0, 9) < 7,
                      $urandom_range(0, 9) < 3,
                      $urandom_range(0, 399) == 0);
            end
            for (int rel = 0; rel < 3; rel++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
